// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit memory controller.
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    // Controller sequencing: one memory strobe cycle, one capture cycle, then hold the response
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_t;

    // Byte enables for an access of the given size at byte offset off within the word
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << off;
            SIZE_HALF: m = 4'b0011 << off;
            default:   m = 4'hF;
        endcase
        return m;
    endfunction

    // Reserved size or a half/word that is not naturally aligned
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic e;
        case (size)
            SIZE_HALF: e = off[0];
            SIZE_WORD: e = (off != 2'b00);
            SIZE_RSVD: e = 1'b1;
            default:   e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_fmt.sv
// Combinational lane steering: places store data/enables on byte lanes and
// extracts plus extends load data from the raw memory word.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_be,
    output logic [31:0] load_data
);

    logic [31:0] rdata_sh;

    // Sign- or zero-extend a byte to a full word
    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
        logic signed [7:0] sb;
        sb = b;
        return uns ? {24'd0, b} : 32'(sb);
    endfunction

    // Sign- or zero-extend a halfword to a full word
    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
        logic signed [15:0] sh;
        sh = h;
        return uns ? {16'd0, h} : 32'(sh);
    endfunction

    assign lane_wdata = wdata << {off, 3'b000};
    assign lane_be    = lane_mask(size, off);
    assign rdata_sh   = rdata >> {off, 3'b000};

    // Select and extend the addressed bytes of the returned word
    always_comb begin
        load_data = rdata_sh;
        case (size)
            SIZE_BYTE: load_data = ext_byte(rdata_sh[7:0], is_unsigned);
            SIZE_HALF: load_data = ext_half(rdata_sh[15:0], is_unsigned);
            default:   load_data = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller between a core request/response
// handshake and a one-cycle-latency word memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_write_mask,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        state;
    lsu_state_t        state_nxt;
    logic              accept;

    logic              write_p0;
    logic [1:0]        size_p0;
    logic              uns_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;
    logic [DATA_W-1:0] load_data;

    assign accept = req_valid & req_ready;

    // State register; reset aborts any access in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: bad accesses skip the memory and answer immediately
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (req_valid)
                            state_nxt = access_err(req_size, req_addr[1:0]) ? ST_RESP : ST_ACCESS;
            ST_ACCESS:  state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_RESP;
            ST_RESP:    if (resp_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from state so reset clears them at once
    always_comb begin
        req_ready        = (state == ST_IDLE);
        mem_valid        = (state == ST_ACCESS);
        mem_write_enable = (state == ST_ACCESS) & write_p0;
        resp_valid       = (state == ST_RESP);
    end

    // Stage p0: request fields captured at accept, frozen while busy
    always_ff @(posedge clock) begin
        if (accept) begin
            write_p0 <= req_write;
            size_p0  <= req_size;
            uns_p0   <= req_unsigned;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    assign mem_write_addr = {addr_p0[ADDR_W-1:2], 2'b00};
    assign mem_read_addr  = {addr_p0[ADDR_W-1:2], 2'b00};

    lsu_lane_fmt u_lane_fmt (
        .size        (size_p0),
        .is_unsigned (uns_p0),
        .off         (addr_p0[1:0]),
        .wdata       (wdata_p0),
        .rdata       (mem_read_data),
        .lane_wdata  (mem_write_data),
        .lane_be     (mem_write_mask),
        .load_data   (load_data)
    );

    // Stage p1: response word/flag, cleared at accept, loaded in CAPTURE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept) begin
            rdata_p1 <= '0;
            err_p1   <= access_err(req_size, req_addr[1:0]);
        end else if (state == ST_CAPTURE) begin
            rdata_p1 <= write_p0 ? '0 : load_data;
        end
    end

    assign resp_rdata = rdata_p1;
    assign resp_err   = err_p1;

endmodule
